// File: rtl/loader_pkg.sv
// Shared types for the CPU program loader: sequencer states and the default pad word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR_RF,
        CLR_DM,
        LOAD,
        FILL,
        RUN,
        DONE
    } state_t;

    localparam logic [17:0] NOP_WORD = 18'h00000;

endpackage

// File: rtl/loader_cnt.sv
// Up-counter with synchronous clear and enable; tc flags the terminal value.
module loader_cnt #(
    parameter int W      = 4,
    parameter int TC_VAL = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TC_VAL));

endmodule

// File: rtl/cpu_program_loader.sv
// Boot/run controller: clears RF and a DMEM window, streams a program into IMEM, pads it, runs the CPU.
// Optional LOADER_CHECKSUM_EN adds load_sum, a running sum of accepted program words.
module cpu_program_loader
    import loader_pkg::*;
#(
    parameter int                 INSTR_W    = 18,
    parameter int                 IMEM_DEPTH = 256,
    parameter int                 NUM_REGS   = 8,
    parameter int                 DATA_W     = 18,
    parameter int                 DMEM_CLEAR = 16,
    parameter logic [INSTR_W-1:0] FILL_WORD  = NOP_WORD,
    parameter int                 MAX_CYCLES = 1024,
    parameter int                 IA_W       = $clog2(IMEM_DEPTH),
    parameter int                 RA_W       = $clog2(NUM_REGS),
    parameter int                 DA_W       = $clog2(DMEM_CLEAR),
    parameter int                 CYC_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [INSTR_W-1:0] src_data,
    input  logic               src_last,
    output logic               imem_we,
    output logic [IA_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               dmem_we,
    output logic [DA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               rf_we,
    output logic [RA_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               cpu_reset,
    output logic               cpu_en,
    input  logic               cpu_halt,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               load_ovf,
    output logic [IA_W:0]      words_loaded,
`ifdef LOADER_CHECKSUM_EN
    output logic [INSTR_W-1:0] load_sum,
`endif
    output logic [CYC_W-1:0]   cycle_count
);

    state_t state, next;
    logic   start_go, hs;
    logic   rf_tc, dm_tc, ia_tc, cyc_tc;

    assign start_go = start && (state == IDLE || state == DONE);
    assign hs       = (state == LOAD) && src_valid;

    // Clear counters also self-clear at terminal count so non-power-of-2 sizes restart at 0.
    loader_cnt #(.W(RA_W), .TC_VAL(NUM_REGS - 1)) u_rf_cnt (
        .clk(clk), .reset(reset), .clr(start_go || (state == CLR_RF && rf_tc)),
        .en(state == CLR_RF), .cnt(rf_addr), .tc(rf_tc)
    );

    loader_cnt #(.W(DA_W), .TC_VAL(DMEM_CLEAR - 1)) u_dm_cnt (
        .clk(clk), .reset(reset), .clr(start_go || (state == CLR_DM && dm_tc)),
        .en(state == CLR_DM), .cnt(dmem_addr), .tc(dm_tc)
    );

    // One IMEM address counter walks both the load and the fill phases.
    loader_cnt #(.W(IA_W), .TC_VAL(IMEM_DEPTH - 1)) u_ia_cnt (
        .clk(clk), .reset(reset), .clr(start_go),
        .en(hs || state == FILL), .cnt(imem_addr), .tc(ia_tc)
    );

    loader_cnt #(.W(CYC_W), .TC_VAL(MAX_CYCLES - 1)) u_cyc_cnt (
        .clk(clk), .reset(reset), .clr(start_go),
        .en(state == RUN), .cnt(cycle_count), .tc(cyc_tc)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = CLR_RF;
            CLR_RF:  if (rf_tc) next = CLR_DM;
            CLR_DM:  if (dm_tc) next = LOAD;
            LOAD: begin
                if (hs) begin
                    if (src_last)   next = ia_tc ? RUN : FILL;
                    else if (ia_tc) next = DONE;
                end
            end
            FILL:    if (ia_tc) next = RUN;
            RUN:     if (cpu_halt || cyc_tc) next = DONE;
            DONE:    if (start) next = CLR_RF;
            default: next = IDLE;
        endcase
    end

    assign src_ready  = (state == LOAD);
    assign rf_we      = (state == CLR_RF);
    assign dmem_we    = (state == CLR_DM);
    assign imem_we    = hs || (state == FILL);
    assign imem_wdata = (state == FILL) ? FILL_WORD : src_data;
    assign rf_wdata   = '0;
    assign dmem_wdata = '0;

    // Status is registered from next so it lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cpu_reset    <= 1'b1;
            cpu_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            load_ovf     <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            load_sum     <= '0;
`endif
        end else begin
            state     <= next;
            cpu_reset <= next inside {IDLE, CLR_RF, CLR_DM, LOAD, FILL};
            cpu_en    <= (next == RUN);
            busy      <= !(next inside {IDLE, DONE});
            done      <= (next == DONE);
            if (start_go) begin
                timeout      <= 1'b0;
                load_ovf     <= 1'b0;
                words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                load_sum     <= '0;
`endif
            end else begin
                if (hs) begin
                    words_loaded <= words_loaded + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    load_sum     <= load_sum + src_data;
`endif
                end
                if (hs && !src_last && ia_tc)
                    load_ovf <= 1'b1;
                // Halt takes priority over budget expiry.
                if (state == RUN && !cpu_halt && cyc_tc)
                    timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: expected writes/status queued at stimulus, popped by a monitor.
module tb_cpu_program_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset, start, src_valid, src_last, cpu_halt;
    logic [17:0] src_data;
    logic        src_ready, imem_we, dmem_we, rf_we;
    logic [7:0]  imem_addr;
    logic [17:0] imem_wdata, dmem_wdata, rf_wdata;
    logic [3:0]  dmem_addr;
    logic [2:0]  rf_addr;
    logic        cpu_reset, cpu_en, busy, done, timeout, load_ovf;
    logic [8:0]  words_loaded;
    logic [10:0] cycle_count;
`ifdef LOADER_CHECKSUM_EN
    logic [17:0] load_sum;
`endif

    cpu_program_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .cpu_halt(cpu_halt),
        .busy(busy), .done(done), .timeout(timeout), .load_ovf(load_ovf),
        .words_loaded(words_loaded),
`ifdef LOADER_CHECKSUM_EN
        .load_sum(load_sum),
`endif
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int addr; int data; } wr_t;
    typedef struct { int words; int cyc; int tmo; int ovf; } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    int  total = 0;
    int  bad   = 0;
    int  ld;
    bit  en_seen;
    logic done_d = 1'b0;
    logic [17:0] prog [7] = '{18'h08004, 18'h24000, 18'h20400, 18'h04840,
                              18'h24801, 18'h0cc81, 18'h24c00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every rising done consumes one expected entry.
    wr_t mw;
    st_t ms;
    always @(negedge clk) begin
        if (rf_we === 1'b1 || dmem_we === 1'b1 || imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hffff_ffff);
            end else begin
                mw = wr_q.pop_front();
                if (rf_we === 1'b1) begin
                    chk("wr_kind", 0, mw.kind);
                    chk("rf_addr", 32'(rf_addr), mw.addr);
                    chk("rf_wdata", 32'(rf_wdata), mw.data);
                end else if (dmem_we === 1'b1) begin
                    chk("wr_kind", 1, mw.kind);
                    chk("dmem_addr", 32'(dmem_addr), mw.addr);
                    chk("dmem_wdata", 32'(dmem_wdata), mw.data);
                end else begin
                    chk("wr_kind", 2, mw.kind);
                    chk("imem_addr", 32'(imem_addr), mw.addr);
                    chk("imem_wdata", 32'(imem_wdata), mw.data);
                end
            end
        end
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (st_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                ms = st_q.pop_front();
                chk("words_loaded", 32'(words_loaded), ms.words);
                chk("cycle_count", 32'(cycle_count), ms.cyc);
                chk("timeout", 32'(timeout), ms.tmo);
                chk("load_ovf", 32'(load_ovf), ms.ovf);
                chk("cpu_en_at_done", 32'(cpu_en), 0);
                chk("cpu_reset_at_done", 32'(cpu_reset), 0);
            end
        end
        done_d = done;
        if (cpu_en === 1'b1) en_seen = 1'b1;
    end

    task automatic do_start(input bit from_done);
        for (int i = 0; i < 8; i++)  wr_q.push_back('{0, i, 0});
        for (int i = 0; i < 16; i++) wr_q.push_back('{1, i, 0});
        ld = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        en_seen = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("done_cleared", 32'(done), 0);
        if (from_done) begin
            chk("timeout_cleared", 32'(timeout), 0);
            chk("load_ovf_cleared", 32'(load_ovf), 0);
            chk("words_cleared", 32'(words_loaded), 0);
            chk("cycles_cleared", 32'(cycle_count), 0);
`ifdef LOADER_CHECKSUM_EN
            chk("load_sum_cleared", 32'(load_sum), 0);
`endif
        end
    endtask

    task automatic send(input logic [17:0] d, input bit last);
        bit hs;
        wr_q.push_back('{2, ld, int'(d)});
        if (last)
            for (int a = ld + 1; a < DEPTH; a++) wr_q.push_back('{2, a, 0});
        ld++;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = last;
        hs = 1'b0;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = src_ready;
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
        if (!hs) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_run();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (cpu_en === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) chk("run_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic halt_at(input int n);
        wait_run();
        repeat (n - 1) begin @(posedge clk); #1; end
        cpu_halt = 1'b1;
        @(posedge clk); #1;
        cpu_halt = 1'b0;
    endtask

    initial begin
        logic [17:0] sum;
        reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_last = 1'b0;
        src_data = '0; cpu_halt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_we", 32'({rf_we, dmem_we, imem_we}), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_status", 32'({busy, done, timeout, load_ovf}), 0);
        chk("rst_words", 32'(words_loaded), 0);
        chk("rst_cycles", 32'(cycle_count), 0);
        chk("rst_addrs", 32'({rf_addr, dmem_addr, imem_addr}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 7-word program, halt during RUN cycle 20
        do_start(1'b0);
        sum = '0;
        for (int i = 0; i < 7; i++) begin
            send(prog[i], i == 6);
            sum = sum + prog[i];
        end
        st_q.push_back('{7, 20, 0, 0});
        halt_at(20);
        wait_done(10);
`ifdef LOADER_CHECKSUM_EN
        chk("load_sum", 32'(load_sum), 32'(sum));
`endif

        // Same program, no halt: budget expiry
        do_start(1'b1);
        for (int i = 0; i < 7; i++) send(prog[i], i == 6);
        st_q.push_back('{7, 1024, 1, 0});
        wait_done(1400);
        chk("timeout_level", 32'(timeout), 1);

        // 256 words without last: overflow, CPU never enabled
        do_start(1'b1);
        st_q.push_back('{256, 0, 0, 1});
        for (int i = 0; i < DEPTH; i++) send(18'(i * 37 + 5), 1'b0);
        wait_done(10);
        chk("ovf_cpu_en_never", 32'(en_seen), 0);

        // valid pattern 1-0-0-1 between words
        do_start(1'b1);
        send(18'h11111, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        send(18'h22222, 1'b0);
        send(18'h33333, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        st_q.push_back('{4, 3, 0, 0});
        send(18'h3ffff, 1'b1);
        halt_at(3);
        wait_done(10);

        // reset mid-LOAD after word 3
        do_start(1'b1);
        send(18'h00abc, 1'b0);
        send(18'h00def, 1'b0);
        send(18'h01234, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", 32'({rf_we, dmem_we, imem_we}), 0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 1);
        chk("midrst_words", 32'(words_loaded), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_src_ready", 32'(src_ready), 0);
        reset = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("idle_no_busy", 32'(busy), 0);

        chk("wr_q_empty", 32'(wr_q.size()), 0);
        chk("st_q_empty", 32'(st_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
